// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external 8-bit ALU: owns a small register file, issues one op at a time,
// returns each result on a valid/ready response channel. Optional response counter: ALU_SEQ_OPCOUNT_EN.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_load,
    input  logic [1:0]                 cmd_sel,
    input  logic [$clog2(NREGS)-1:0]   cmd_dst,
    input  logic [$clog2(NREGS)-1:0]   cmd_srca,
    input  logic [$clog2(NREGS)-1:0]   cmd_srcb,
    input  logic [WIDTH-1:0]           cmd_imm,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [1:0]                 alu_sel,
    input  logic [WIDTH-1:0]           alu_out,
    input  logic                       alu_cout,
    input  logic                       alu_zero,
`ifdef ALU_SEQ_OPCOUNT_EN
    output logic [15:0]                op_count,
`endif
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_carry,
    output logic                       rsp_zero
);

    localparam int IDXW = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  rf_q [NREGS];
    logic [WIDTH-1:0]  rf_d [NREGS];
    logic [IDXW-1:0]   dst_q, dst_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [1:0]        alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_zero_q, rsp_zero_d;
`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0]       op_count_q, op_count_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            dst_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= 2'b00;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
`ifdef ALU_SEQ_OPCOUNT_EN
            op_count_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            dst_q       <= dst_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_SEQ_OPCOUNT_EN
            op_count_q  <= op_count_d;
`endif
        end
    end

    // Operands are sampled from the register file at the accept edge, so a destination that
    // aliases a source sees the old value and only the write-back changes it.
    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        dst_d       = dst_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
`ifdef ALU_SEQ_OPCOUNT_EN
        op_count_d  = op_count_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        rf_d[cmd_dst] = cmd_imm;
                        rsp_data_d    = cmd_imm;
                        rsp_carry_d   = 1'b0;
                        rsp_zero_d    = (cmd_imm == '0);
                        state_d       = DONE;
                    end else begin
                        alu_a_d   = rf_q[cmd_srca];
                        alu_b_d   = rf_q[cmd_srcb];
                        alu_sel_d = cmd_sel;
                        dst_d     = cmd_dst;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                rf_d[dst_q] = alu_out;
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_cout;
                rsp_zero_d  = alu_zero;
                state_d     = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
`ifdef ALU_SEQ_OPCOUNT_EN
                    op_count_d = op_count_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
`ifdef ALU_SEQ_OPCOUNT_EN
    assign op_count  = op_count_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural AND/XOR/ADD/LSHIFT ALU beside it.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [1:0] cmd_sel = 2'b00;
    logic [1:0] cmd_dst = 2'b00;
    logic [1:0] cmd_srca = 2'b00;
    logic [1:0] cmd_srcb = 2'b00;
    logic [7:0] cmd_imm = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_zero;
`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0] op_count;
`endif

    int pass_count = 0;
    int total_count = 0;
    int lat;
    logic [7:0] held_data;

    always #5 clk = ~clk;

    // Reference ALU: carry is the ninth sum bit for ADD and the bit shifted out for LSHIFT.
    always_comb begin
        alu_cout = 1'b0;
        alu_out  = 8'h00;
        case (alu_sel)
            2'b00: alu_out = alu_a & alu_b;
            2'b01: alu_out = alu_a ^ alu_b;
            2'b10: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            default: {alu_cout, alu_out} = {alu_a, 1'b0};
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    alu_op_sequencer #(.WIDTH(8), .NREGS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_sel   (cmd_sel),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .alu_zero  (alu_zero),
`ifdef ALU_SEQ_OPCOUNT_EN
        .op_count  (op_count),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Waits in IDLE, presents one command for exactly one accept edge, returns #1 after that edge.
    task automatic applyStimulus(input logic load, input logic [1:0] sel, input logic [1:0] dst,
                                 input logic [1:0] srca, input logic [1:0] srcb, input logic [7:0] imm);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) checkOutput("idle_timeout", 16'(cmd_ready), 16'd1);
        cmd_load  = load;
        cmd_sel   = sel;
        cmd_dst   = dst;
        cmd_srca  = srca;
        cmd_srcb  = srcb;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!rsp_valid) checkOutput("rsp_timeout", 16'(rsp_valid), 16'd1);
    endtask

    task automatic finishRsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic checkRsp(input string tag, input logic [7:0] data, input logic carry, input logic zero);
        checkOutput({tag, "_data"}, 16'(rsp_data), 16'(data));
        checkOutput({tag, "_carry"}, 16'(rsp_carry), 16'(carry));
        checkOutput({tag, "_zero"}, 16'(rsp_zero), 16'(zero));
    endtask

    task automatic doLoad(input logic [1:0] dst, input logic [7:0] imm);
        applyStimulus(1'b1, 2'b00, dst, 2'd0, 2'd0, imm);
        waitRsp(lat);
        finishRsp();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        checkOutput("rst_alu_a", 16'(alu_a), 16'd0);
        checkOutput("rst_alu_sel", 16'(alu_sel), 16'd0);
        checkOutput("rst_rsp_data", 16'(rsp_data), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_cmd_ready", 16'(cmd_ready), 16'd1);
        checkOutput("rel_rsp_valid", 16'(rsp_valid), 16'd0);

        // All registers read zero after reset
        applyStimulus(1'b0, 2'b00, 2'd0, 2'd2, 2'd3, 8'h00);
        checkOutput("rf0_a", 16'(alu_a), 16'h00);
        checkOutput("rf0_b", 16'(alu_b), 16'h00);
        waitRsp(lat);
        finishRsp();
        applyStimulus(1'b0, 2'b00, 2'd0, 2'd0, 2'd1, 8'h00);
        checkOutput("rf1_a", 16'(alu_a), 16'h00);
        checkOutput("rf1_b", 16'(alu_b), 16'h00);
        waitRsp(lat);
        checkRsp("rf_zero_and", 8'h00, 1'b0, 1'b1);
        finishRsp();

        // Loads, then AND r2 = r0 & r1, with latency checks
        applyStimulus(1'b1, 2'b00, 2'd0, 2'd0, 2'd0, 8'h0F);
        checkOutput("load_valid_now", 16'(rsp_valid), 16'd1);
        waitRsp(lat);
        checkOutput("load_latency", 16'(lat), 16'd0);
        checkRsp("load0f", 8'h0F, 1'b0, 1'b0);
        finishRsp();
        doLoad(2'd1, 8'h3C);
        applyStimulus(1'b0, 2'b00, 2'd2, 2'd0, 2'd1, 8'h00);
        checkOutput("and_alu_a", 16'(alu_a), 16'h0F);
        checkOutput("and_alu_b", 16'(alu_b), 16'h3C);
        checkOutput("and_alu_sel", 16'(alu_sel), 16'd0);
        checkOutput("issue_not_ready", 16'(cmd_ready), 16'd0);
        checkOutput("issue_no_valid", 16'(rsp_valid), 16'd0);
        waitRsp(lat);
        checkOutput("alu_latency", 16'(lat), 16'd2);
        checkRsp("and", 8'h0C, 1'b0, 1'b0);
        finishRsp();

        // ADD r3 = r0 + r1 with carry out, then read r3 back through XOR r2 = r3 ^ r2
        doLoad(2'd0, 8'hF0);
        doLoad(2'd1, 8'h20);
        applyStimulus(1'b0, 2'b10, 2'd3, 2'd0, 2'd1, 8'h00);
        checkOutput("add_alu_sel", 16'(alu_sel), 16'd2);
        waitRsp(lat);
        checkRsp("add", 8'h10, 1'b1, 1'b0);
        finishRsp();
        applyStimulus(1'b0, 2'b01, 2'd2, 2'd3, 2'd2, 8'h00);
        checkOutput("rf3_readback", 16'(alu_a), 16'h10);
        checkOutput("rf2_readback", 16'(alu_b), 16'h0C);
        waitRsp(lat);
        checkRsp("xor_mix", 8'h1C, 1'b0, 1'b0);
        finishRsp();

        // XOR r1 = r1 ^ r1 gives zero; then LSHIFT of 0x81 with srcb still driven
        applyStimulus(1'b0, 2'b01, 2'd1, 2'd1, 2'd1, 8'h00);
        waitRsp(lat);
        checkRsp("xor_self", 8'h00, 1'b0, 1'b1);
        finishRsp();
        doLoad(2'd1, 8'h81);
        applyStimulus(1'b0, 2'b11, 2'd1, 2'd1, 2'd0, 8'h00);
        checkOutput("lsh_alu_sel", 16'(alu_sel), 16'd3);
        checkOutput("lsh_alu_a", 16'(alu_a), 16'h81);
        checkOutput("lsh_alu_b", 16'(alu_b), 16'hF0);
        waitRsp(lat);
        checkRsp("lsh", 8'h02, 1'b1, 1'b0);
        finishRsp();

        // Zero immediate sets zero flag; aliased dst/src uses old value
        applyStimulus(1'b1, 2'b00, 2'd2, 2'd0, 2'd0, 8'h00);
        waitRsp(lat);
        checkRsp("load_zero", 8'h00, 1'b0, 1'b1);
        finishRsp();
        applyStimulus(1'b0, 2'b10, 2'd1, 2'd1, 2'd1, 8'h00);
        checkOutput("alias_a", 16'(alu_a), 16'h02);
        waitRsp(lat);
        checkRsp("alias_add", 8'h04, 1'b0, 1'b0);
        finishRsp();
        applyStimulus(1'b0, 2'b00, 2'd0, 2'd1, 2'd1, 8'h00);
        checkOutput("alias_written", 16'(alu_a), 16'h04);
        waitRsp(lat);

        // Back-pressure: held in DONE while a load is offered
        held_data = 8'h04;
        cmd_load  = 1'b1;
        cmd_dst   = 2'd3;
        cmd_imm   = 8'hA5;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_ready_%0d", i), 16'(cmd_ready), 16'd0);
            checkOutput($sformatf("bp_valid_%0d", i), 16'(rsp_valid), 16'd1);
            checkOutput($sformatf("bp_data_%0d", i), 16'(rsp_data), 16'(held_data));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checkOutput("bp_idle", 16'(cmd_ready), 16'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checkOutput("bp_second_valid", 16'(rsp_valid), 16'd1);
        checkRsp("bp_second", 8'hA5, 1'b0, 1'b0);
        finishRsp();
        applyStimulus(1'b0, 2'b00, 2'd0, 2'd3, 2'd3, 8'h00);
        checkOutput("bp_rf3", 16'(alu_a), 16'hA5);
        waitRsp(lat);
        finishRsp();

        // Reset asserted mid-ISSUE discards the operation
        doLoad(2'd0, 8'h55);
        applyStimulus(1'b0, 2'b10, 2'd0, 2'd0, 2'd0, 8'h00);
        checkOutput("pre_rst_alu_a", 16'(alu_a), 16'h55);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", 16'(cmd_ready), 16'd1);
        checkOutput("mid_rst_valid", 16'(rsp_valid), 16'd0);
        checkOutput("mid_rst_alu_a", 16'(alu_a), 16'h00);
        checkOutput("mid_rst_data", 16'(rsp_data), 16'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 2'd1, 2'd0, 2'd3, 8'h00);
        checkOutput("post_rst_r0", 16'(alu_a), 16'h00);
        checkOutput("post_rst_r3", 16'(alu_b), 16'h00);
        waitRsp(lat);
        finishRsp();

`ifdef ALU_SEQ_OPCOUNT_EN
        doLoad(2'd1, 8'h11);
        doLoad(2'd2, 8'h22);
        @(negedge clk);
        checkOutput("op_count_3", op_count, 16'd3);
        force dut.op_count_q = 16'hFFFE;
        #1 release dut.op_count_q;
        doLoad(2'd1, 8'h33);
        @(negedge clk);
        checkOutput("op_count_ffff", op_count, 16'hFFFF);
        doLoad(2'd1, 8'h44);
        @(negedge clk);
        checkOutput("op_count_wrap", op_count, 16'h0000);
`endif

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
